// File: rtl/line_burst_adapter.sv
// line_burst_adapter: splits one cache-line transaction into WORDS_PER_LINE
// ascending 32-bit word beats on the main-memory port. Fills are assembled
// into resp_rdata. Writebacks are driven from a captured copy of the line.
// Both end with a single resp_valid pulse.
module line_burst_adapter #(
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned BEAT_W         = 2
) (
  input  logic                          clk,
  input  logic                          RESET,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_rw,
  input  logic [31:0]                   req_addr,
  input  logic [32*WORDS_PER_LINE-1:0]  req_wdata,
  output logic                          resp_valid,
  output logic [32*WORDS_PER_LINE-1:0]  resp_rdata,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [31:0]                   mem_addr,
  output logic [31:0]                   mem_wdata,
  output logic [3:0]                    mem_be,
  input  logic                          mem_gnt,
  input  logic                          mem_rvalid,
  input  logic [31:0]                   mem_rdata
);

  localparam int unsigned      LINE_W    = 32 * WORDS_PER_LINE;
  localparam int unsigned      OFF_W     = BEAT_W + 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_WAIT,
    WR,
    RESP
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [BEAT_W-1:0]   beat;
  logic [BEAT_W-1:0]   beat_nx;
  logic [31-OFF_W:0]   line_addr;
  logic [LINE_W-1:0]   line_wdata;
  logic                accept;
  logic                rd_store;

  // Byte-within-line offset bits of the request address are ignored.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^req_addr[OFF_W-1:0];

  // Next-state and beat sequencing; a beat advances only on grant (writes)
  // or on read return (fills), and the last beat exits before any wrap.
  always_comb begin
    state_nx = state;
    beat_nx  = beat;
    accept   = 1'b0;
    rd_store = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          accept   = 1'b1;
          beat_nx  = '0;
          state_nx = req_rw ? WR : RD_ADDR;
        end
      end
      WR: begin
        if (mem_gnt) begin
          if (beat == LAST_BEAT) state_nx = RESP;
          else                   beat_nx  = beat + BEAT_W'(1);
        end
      end
      RD_ADDR: begin
        if (mem_gnt) state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          rd_store = 1'b1;
          if (beat == LAST_BEAT) begin
            state_nx = RESP;
          end else begin
            beat_nx  = beat + BEAT_W'(1);
            state_nx = RD_ADDR;
          end
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and beat registers.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_nx;
      beat  <= beat_nx;
    end
  end

  // Capture the line address and writeback data at accept so the cache may
  // change its request lines freely afterwards.
  always_ff @(posedge clk) begin
    if (RESET) begin
      line_addr  <= '0;
      line_wdata <= '0;
    end else if (accept) begin
      line_addr  <= req_addr[31:OFF_W];
      line_wdata <= req_wdata;
    end
  end

  // Fill assembly: each returned word lands in its slot of resp_rdata.
  always_ff @(posedge clk) begin
    if (RESET) begin
      resp_rdata <= '0;
    end else if (rd_store) begin
      for (int unsigned k = 0; k < WORDS_PER_LINE; k++) begin
        if (beat == BEAT_W'(k)) resp_rdata[32*k +: 32] <= mem_rdata;
      end
    end
  end

  // Select the current beat's word from the captured writeback line.
  always_comb begin
    mem_wdata = '0;
    for (int unsigned k = 0; k < WORDS_PER_LINE; k++) begin
      if (beat == BEAT_W'(k)) mem_wdata = line_wdata[32*k +: 32];
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_req    = (state == WR) || (state == RD_ADDR);
  assign mem_we     = (state == WR);
  assign mem_be     = {4{mem_we}};
  assign mem_addr   = {line_addr, beat, 2'b00};

endmodule

// File: tb/tb_line_burst_adapter.sv
// Self-checking bench for line_burst_adapter: a randomized memory responder,
// a transaction-level reference model checked every cycle, and directed
// cases with hand-computed expectations.
module tb_line_burst_adapter;

  logic         clk;
  logic         RESET;
  logic         req_valid;
  logic         req_ready;
  logic         req_rw;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic         resp_valid;
  logic [127:0] resp_rdata;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_be;
  logic         mem_gnt;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;

  line_burst_adapter #(.WORDS_PER_LINE(4), .BEAT_W(2)) dut (
    .clk(clk), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passes = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- memory responder knobs and state ----------------
  int unsigned max_stall = 0;
  int unsigned lat_min   = 1;
  int unsigned lat_max   = 1;
  bit          stray_en  = 0;
  int unsigned stall_left = 0;
  int unsigned rd_cnt     = 0;
  logic [31:0] rd_data;
  logic [31:0] mem_init [logic [31:0]];

  initial begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (rd_cnt != 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rd_data;
        end
      end
      if (mem_req) begin
        if (stall_left != 0) begin
          mem_gnt = 1'b0;
          stall_left--;
        end else begin
          mem_gnt    = 1'b1;
          stall_left = $urandom_range(0, max_stall);
          if (!mem_we) begin
            rd_cnt = $urandom_range(lat_min, lat_max);
            if (mem_init.exists(mem_addr)) rd_data = mem_init[mem_addr];
            else                           rd_data = $urandom;
          end
        end
      end else begin
        mem_gnt = (max_stall == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if (stray_en && rd_cnt == 0 && !mem_rvalid && $urandom_range(0, 2) == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  bit          m_valid = 0;
  bit          m_busy, m_wait, m_resp, m_rw;
  int unsigned m_beat;
  logic [31:0] m_base;
  logic [31:0] m_words [4];
  logic [31:0] m_fill  [4];
  logic [127:0] m_rdata;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  int unsigned dut_resp_cyc = 0;
  int unsigned dut_resp_count = 0;
  int unsigned rd_returns = 0;
  logic [127:0] dut_resp_data;
  logic [31:0] obs_addr [$];
  logic [31:0] obs_wdata [$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (resp_valid) begin
        dut_resp_count++;
        dut_resp_cyc  = cyc;
        dut_resp_data = resp_rdata;
      end
      if (m_valid) begin
        bit e_ready, e_req, e_we;
        e_ready = !m_busy && !m_resp;
        e_req   = m_busy && !m_wait;
        e_we    = e_req && m_rw;
        check("req_ready", req_ready, e_ready);
        check("resp_valid", resp_valid, m_resp);
        check("mem_req", mem_req, e_req);
        check("mem_we", mem_we, e_we);
        check("mem_be", mem_be, e_we ? 4'hF : 4'h0);
        if (e_req) begin
          check("mem_addr", mem_addr, m_base + 32'(4 * m_beat));
          if (m_rw) check("mem_wdata", mem_wdata, m_words[m_beat]);
        end
        if (!m_busy) check("resp_rdata", resp_rdata, m_rdata);
      end
      if (RESET) begin
        m_valid = 1; m_busy = 0; m_wait = 0; m_resp = 0; m_beat = 0;
        m_rdata = '0;
      end else if (m_valid) begin
        if (m_resp) begin
          m_resp = 0;
        end else if (!m_busy) begin
          if (req_valid) begin
            m_busy = 1; m_wait = 0; m_beat = 0; m_rw = req_rw;
            m_base = {req_addr[31:4], 4'h0};
            for (int k = 0; k < 4; k++) m_words[k] = req_wdata[32*k +: 32];
            acc_cyc = cyc;
          end
        end else if (!m_wait) begin
          if (mem_gnt) begin
            obs_addr.push_back(mem_addr);
            obs_wdata.push_back(mem_wdata);
            if (!m_rw) m_wait = 1;
            else if (m_beat == 3) begin m_busy = 0; m_resp = 1; end
            else m_beat++;
          end
        end else if (mem_rvalid) begin
          rd_returns++;
          m_fill[m_beat] = mem_rdata;
          m_wait = 0;
          if (m_beat == 3) begin
            m_busy = 0; m_resp = 1;
            m_rdata = {m_fill[3], m_fill[2], m_fill[1], m_fill[0]};
          end else m_beat++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int unsigned base_resp;

  task automatic issue(input logic rw, input logic [31:0] addr, input logic [127:0] wd);
    int unsigned n = 0;
    while (!req_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (!req_ready) check("ready_timeout", req_ready, 1'b1);
    obs_addr.delete();
    obs_wdata.delete();
    base_resp = dut_resp_count;
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_rw    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_resp();
    int unsigned n = 0;
    while (dut_resp_count == base_resp && n < 400) begin @(posedge clk); #1; n++; end
    check("resp_count", dut_resp_count - base_resp, 1);
  endtask

  logic [31:0] exp_wa [4] = '{32'h0000_1230, 32'h0000_1234, 32'h0000_1238, 32'h0000_123C};
  logic [31:0] exp_wd [4] = '{32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD};

  initial begin
    int unsigned base_ret;
    int unsigned n;
    RESET = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
    mem_init[32'h5000] = 32'h11; mem_init[32'h5004] = 32'h22;
    mem_init[32'h5008] = 32'h33; mem_init[32'h500C] = 32'h44;
    mem_init[32'h6000] = 32'hA0; mem_init[32'h6004] = 32'hB0;
    mem_init[32'h6008] = 32'hC0; mem_init[32'h600C] = 32'hD0;
    repeat (2) @(posedge clk);
    #1 RESET = 1'b0;

    check("rst_req_ready", req_ready, 1'b1);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 128'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_be", mem_be, 4'h0);

    // Writeback, grant always high.
    stall_left = 0; max_stall = 0;
    issue(1'b1, 32'h0000_1234, 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA);
    wait_resp();
    check("wr_beats", obs_addr.size(), 4);
    if (obs_addr.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("wr_addr", obs_addr[k], exp_wa[k]);
        check("wr_data", obs_wdata[k], exp_wd[k]);
      end
    end
    check("wr_latency", dut_resp_cyc - acc_cyc, 5);

    // Line fill, latency 1.
    lat_min = 1; lat_max = 1;
    issue(1'b0, 32'h0000_5000, '0);
    wait_resp();
    check("fill_data", dut_resp_data, 128'h0000_0044_0000_0033_0000_0022_0000_0011);
    check("fill_latency", dut_resp_cyc - acc_cyc, 9);

    // Randomized traffic with grant stalls, variable latency, stray returns.
    max_stall = 3; lat_min = 1; lat_max = 5; stray_en = 1;
    for (int t = 0; t < 40; t++) begin
      issue(1'($urandom), $urandom, {$urandom, $urandom, $urandom, $urandom});
      wait_resp();
      check("rand_beats", obs_addr.size(), 4);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // Reset mid-fill with a late return after reset.
    stray_en = 0; max_stall = 0; lat_min = 4; lat_max = 4;
    repeat (12) @(posedge clk);
    #1 stall_left = 0;
    base_ret = rd_returns;
    issue(1'b0, 32'h0000_6000, '0);
    n = 0;
    while (rd_returns < base_ret + 2 && n < 200) begin @(posedge clk); #1; n++; end
    check("midfill_returns", rd_returns - base_ret, 2);
    @(posedge clk); #1 RESET = 1'b1;
    @(posedge clk); #1 RESET = 1'b0;
    check("midfill_idle_ready", req_ready, 1'b1);
    check("midfill_idle_req", mem_req, 1'b0);
    base_resp = dut_resp_count;
    repeat (8) @(posedge clk);
    #1;
    check("midfill_no_resp", dut_resp_count - base_resp, 0);
    max_stall = 3; lat_min = 1; lat_max = 5;
    issue(1'b0, 32'h0000_6000, '0);
    wait_resp();
    check("refill_data", dut_resp_data, 128'h0000_00D0_0000_00C0_0000_00B0_0000_00A0);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1);
  end

endmodule
